// File: rtl/dma_pkg.sv
// dma_pkg: shared channel, state and DPCR layout definitions for the DMA arbiter.
package dma_pkg;
    localparam int NUM_CH        = 7;
    localparam int DPCR_FIELD_W  = 4;
    localparam int DPCR_PRIO_LSB = 0;
    localparam int DPCR_EN_BIT   = 3;
    localparam int PRIO_W        = 3;

    typedef enum logic [2:0] {
        CH_MDECIN  = 3'd0,
        CH_MDECOUT = 3'd1,
        CH_GPU     = 3'd2,
        CH_CDROM   = 3'd3,
        CH_SPU     = 3'd4,
        CH_PIO     = 3'd5,
        CH_OTC     = 3'd6
    } ch_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;
endpackage

// File: rtl/dma_prio_select.sv
// dma_prio_select: picks the eligible channel with the lowest priority value; ties go to the higher index.
module dma_prio_select
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0]        eligible,
    input  logic [NUM_CH*PRIO_W-1:0] prio,
    output logic [2:0]               winner,
    output logic                     found
);
    logic [PRIO_W-1:0] best;

    // Scanning upward with <= lets a later (higher) index win an equal-priority tie.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        best   = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (eligible[i] && (!found || prio[PRIO_W*i +: PRIO_W] <= best)) begin
                found  = 1'b1;
                winner = 3'(i);
                best   = prio[PRIO_W*i +: PRIO_W];
            end
        end
    end
endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: grants the DMA bus master to one of seven channels for a bounded, non-preemptible burst.
// Optional CPU release window after each grant is enabled by defining DMA_CPU_GAP_EN.
module dma_arbiter
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CPU_GAP   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH-1:0]        i_master_en,
    input  logic [NUM_CH*PRIO_W-1:0] i_prio,
    input  logic                     i_word_ack,
    input  logic                     i_done,
    output logic [NUM_CH-1:0]        o_grant,
    output logic [2:0]               o_grant_id,
    output logic                     o_grant_vld,
    output logic                     o_cpu_window,
    output logic [4:0]               o_burst_cnt
);
    state_e            state;
    logic [NUM_CH-1:0] eligible;
    logic [2:0]        winner;
    logic              found;
    logic              burst_end;
    logic              grant_end;

    assign eligible = i_req & i_master_en;

    dma_prio_select u_sel (
        .eligible(eligible),
        .prio    (i_prio),
        .winner  (winner),
        .found   (found)
    );

    // MAX_BURST of 0 makes the compare value all-ones, which the counter never reaches.
    assign burst_end = (MAX_BURST != 0) && i_word_ack && ({27'd0, o_burst_cnt} == 32'(MAX_BURST - 1));
    assign grant_end = i_done || !i_req[o_grant_id] || !i_master_en[o_grant_id] || burst_end;

`ifdef DMA_CPU_GAP_EN
    localparam int GAP_W = (CPU_GAP > 1) ? $clog2(CPU_GAP) : 1;
    logic [GAP_W-1:0] gap_cnt;
`else
    assign o_cpu_window = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= ST_IDLE;
            o_grant      <= '0;
            o_grant_id   <= '0;
            o_grant_vld  <= 1'b0;
            o_burst_cnt  <= '0;
`ifdef DMA_CPU_GAP_EN
            o_cpu_window <= 1'b0;
            gap_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state       <= ST_GRANT;
                        o_grant     <= NUM_CH'(1) << winner;
                        o_grant_id  <= winner;
                        o_grant_vld <= 1'b1;
                        o_burst_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (i_word_ack && o_burst_cnt != 5'd31)
                        o_burst_cnt <= o_burst_cnt + 5'd1;
                    if (grant_end) begin
                        o_grant     <= '0;
                        o_grant_vld <= 1'b0;
`ifdef DMA_CPU_GAP_EN
                        state        <= ST_GAP;
                        o_cpu_window <= 1'b1;
                        gap_cnt      <= GAP_W'(CPU_GAP - 1);
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                ST_GAP: begin
`ifdef DMA_CPU_GAP_EN
                    if (gap_cnt == '0) begin
                        state        <= ST_IDLE;
                        o_cpu_window <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed checks of arbitration, burst limit, done handling and async reset.
module tb_dma_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic [6:0]  req;
    logic [6:0]  en;
    logic [20:0] prio;
    logic        ack;
    logic        done;
    logic [6:0]  grant;
    logic [2:0]  grant_id;
    logic        grant_vld;
    logic        cpu_window;
    logic [4:0]  burst_cnt;
    int          checks = 0;
    int          errors = 0;

    dma_arbiter #(.MAX_BURST(16), .CPU_GAP(4)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_req       (req),
        .i_master_en (en),
        .i_prio      (prio),
        .i_word_ack  (ack),
        .i_done      (done),
        .o_grant     (grant),
        .o_grant_id  (grant_id),
        .o_grant_vld (grant_vld),
        .o_cpu_window(cpu_window),
        .o_burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int ch, input logic [2:0] p);
        prio[3*ch +: 3] = p;
    endtask

    task automatic settle();
        req = '0;
        ack = 1'b0;
        done = 1'b0;
        repeat (8) step();
        prio = '1;
        en = '1;
    endtask

    initial begin
        nrst = 1'b0;
        req  = 7'h7F;
        en   = 7'h7F;
        prio = '0;
        ack  = 1'b0;
        done = 1'b0;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_id", 32'(grant_id), 32'h0);
        check("rst_vld", 32'(grant_vld), 32'h0);
        check("rst_cpu", 32'(cpu_window), 32'h0);
        check("rst_cnt", 32'(burst_cnt), 32'h0);
        nrst = 1'b1;
        step();
        check("t1_grant", 32'(grant), 32'h40);
        check("t1_vld", 32'(grant_vld), 32'h1);
        settle();

        set_prio(2, 3'd1);
        set_prio(4, 3'd3);
        req = 7'h14;
        step();
        check("t2_grant", 32'(grant), 32'h04);
        check("t2_id", 32'(grant_id), 32'h2);
        settle();

        set_prio(5, 3'd3);
        set_prio(6, 3'd3);
        req = 7'h60;
        step();
        check("t3_tie_grant", 32'(grant), 32'h40);
        check("t3_tie_id", 32'(grant_id), 32'h6);
        settle();
        set_prio(5, 3'd3);
        set_prio(6, 3'd3);
        en[6] = 1'b0;
        req = 7'h60;
        step();
        check("t3_en_grant", 32'(grant), 32'h20);
        check("t3_en_id", 32'(grant_id), 32'h5);
        set_prio(0, 3'd0);
        req = 7'h61;
        step();
        check("t3_nopreempt", 32'(grant), 32'h20);
        settle();

        set_prio(0, 3'd0);
        req = 7'h01;
        step();
        check("t4_grant", 32'(grant), 32'h01);
        check("t4_cnt0", 32'(burst_cnt), 32'h0);
        ack = 1'b1;
        repeat (15) step();
        check("t4_cnt15", 32'(burst_cnt), 32'd15);
        check("t4_hold15", 32'(grant), 32'h01);
        step();
        ack = 1'b0;
        check("t4_drop", 32'(grant), 32'h0);
        check("t4_cnt16", 32'(burst_cnt), 32'd16);
        check("t4_vld", 32'(grant_vld), 32'h0);
`ifdef DMA_CPU_GAP_EN
        check("t4_cpu0", 32'(cpu_window), 32'h1);
        for (int k = 1; k < 4; k++) begin
            step();
            check("t4_cpu", 32'(cpu_window), 32'h1);
            check("t4_gap_nogrant", 32'(grant), 32'h0);
        end
        step();
        check("t4_cpu_end", 32'(cpu_window), 32'h0);
        check("t4_idle_nogrant", 32'(grant), 32'h0);
`else
        check("t4_cpu_off", 32'(cpu_window), 32'h0);
`endif
        step();
        check("t4_regrant", 32'(grant), 32'h01);
        check("t4_regrant_cnt", 32'(burst_cnt), 32'h0);
        settle();

        set_prio(3, 3'd0);
        req = 7'h08;
        step();
        check("t5_grant", 32'(grant), 32'h08);
        ack = 1'b1;
        repeat (3) step();
        check("t5_cnt3", 32'(burst_cnt), 32'd3);
        done = 1'b1;
        step();
        ack = 1'b0;
        done = 1'b0;
        check("t5_cnt4", 32'(burst_cnt), 32'd4);
        check("t5_drop", 32'(grant), 32'h0);
        settle();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t5_ack_idle", 32'(burst_cnt), 32'd4);

        set_prio(1, 3'd2);
        set_prio(0, 3'd0);
        req = 7'h02;
        step();
        check("t6_grant", 32'(grant), 32'h02);
        req = 7'h03;
        ack = 1'b1;
        repeat (2) step();
        ack = 1'b0;
        check("t6_hold", 32'(grant), 32'h02);
        check("t6_cnt2", 32'(burst_cnt), 32'd2);
        #2 nrst = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'h0);
        check("t6_async_vld", 32'(grant_vld), 32'h0);
        check("t6_async_cnt", 32'(burst_cnt), 32'h0);
        step();
        nrst = 1'b1;
        step();
        check("t6_after_rst", 32'(grant), 32'h01);
        check("t6_after_id", 32'(grant_id), 32'h0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
